// File: rtl/core_decode_multi_if.sv
// Shared types and the fetch/decode bus for the multi-issue decode stage.
//   core_decode_multi_pkg : halfword pointer, opcode map and the per-lane insn_decode record.
//   core_decode_multi_if  : fetch beat (fetch_valid/insn/pc/count, fetch_ready), pipeline control
//                           (stall, flush), registered decode lanes (dec, dec_valid) and occupancy.
//                           master = fetch/control side, slave = decode stage.

package core_decode_multi_pkg;

    // Halfword-granular program counter.
    typedef logic [15:0] hptr_t;

    typedef enum logic [3:0] {
        OpNop = 4'h0,  // no operation, execute=0
        OpAlu = 4'h1,  // rd = ra op rb
        OpMul = 4'h2,  // rd = ra * rb
        OpImm = 4'h3,  // rd = imm8
        OpLd  = 4'h4,  // rd = mem[ra + imm4]
        OpSt  = 4'h5,  // mem[ra + imm4] = rb, rb taken from bits [11:8]
        OpBal = 4'h6   // rd = link, pc += imm8
    } opcode_e;

    typedef struct packed {
        logic branch;
        logic ldst;
        logic mul;
        logic load;
        logic store;
    } ctrl_t;

    typedef struct packed {
        hptr_t       pc;
        logic [15:0] insn;
        logic        execute;
        logic        illegal;
        ctrl_t       ctrl;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        uses_ra;
        logic        uses_rb;
        logic        writeback;
        logic [7:0]  imm;
    } insn_decode_t;

endpackage

interface core_decode_multi_if #(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned DEPTH   = 8
);
    import core_decode_multi_pkg::*;

    localparam int unsigned FC_W  = $clog2(FETCH_W + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                          fetch_valid;
    logic [FETCH_W*16-1:0]         fetch_insn;
    hptr_t                         fetch_pc;
    logic [FC_W-1:0]               fetch_count;
    logic                          fetch_ready;
    logic                          stall;
    logic                          flush;
    insn_decode_t [ISSUE_W-1:0]    dec;
    logic [ISSUE_W-1:0]            dec_valid;
    logic [CNT_W-1:0]              occupancy;

    modport master (
        output fetch_valid, fetch_insn, fetch_pc, fetch_count, stall, flush,
        input  fetch_ready, dec, dec_valid, occupancy
    );

    modport slave (
        input  fetch_valid, fetch_insn, fetch_pc, fetch_count, stall, flush,
        output fetch_ready, dec, dec_valid, occupancy
    );

endinterface

// File: rtl/core_decode_multi.sv
// Multi-issue decode stage for the 16-bit core.
// Fetched halfwords are buffered in a DEPTH-entry {insn, pc} queue; each cycle an in-order group of
// up to ISSUE_W instructions is formed from the head, decoded and registered onto bus.dec.
// Ports:
//   clk  - core clock
//   rst  - asynchronous reset, active-high
//   bus  - core_decode_multi_if.slave: fetch beat in, fetch_ready/dec/dec_valid/occupancy out,
//          stall and flush control in

module core_decode_multi
    import core_decode_multi_pkg::*;
#(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned DEPTH   = 8
) (
    input logic               clk,
    input logic               rst,
    core_decode_multi_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FC_W  = $clog2(FETCH_W + 1);

    // Field decode; register number 0 is the zero register, so it never creates a dependency.
    function automatic insn_decode_t decode(input logic [15:0] insn, input hptr_t pc);
        insn_decode_t d;
        d      = '0;
        d.pc   = pc;
        d.insn = insn;
        d.rd   = insn[11:8];
        d.ra   = insn[7:4];
        d.rb   = insn[3:0];
        case (insn[15:12])
            OpNop: d.execute = 1'b0;
            OpAlu: begin
                d.execute   = 1'b1;
                d.uses_ra   = 1'b1;
                d.uses_rb   = 1'b1;
                d.writeback = 1'b1;
            end
            OpMul: begin
                d.execute   = 1'b1;
                d.uses_ra   = 1'b1;
                d.uses_rb   = 1'b1;
                d.writeback = 1'b1;
                d.ctrl.mul  = 1'b1;
            end
            OpImm: begin
                d.execute   = 1'b1;
                d.writeback = 1'b1;
                d.imm       = insn[7:0];
            end
            OpLd: begin
                d.execute   = 1'b1;
                d.uses_ra   = 1'b1;
                d.writeback = 1'b1;
                d.ctrl.ldst = 1'b1;
                d.ctrl.load = 1'b1;
                d.imm       = {4'b0, insn[3:0]};
            end
            OpSt: begin
                d.execute    = 1'b1;
                d.uses_ra    = 1'b1;
                d.uses_rb    = 1'b1;
                d.rb         = insn[11:8];
                d.rd         = 4'd0;
                d.ctrl.ldst  = 1'b1;
                d.ctrl.store = 1'b1;
                d.imm        = {4'b0, insn[3:0]};
            end
            OpBal: begin
                d.execute     = 1'b1;
                d.writeback   = 1'b1;
                d.ctrl.branch = 1'b1;
                d.imm         = insn[7:0];
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.ra == 4'd0) d.uses_ra = 1'b0;
        if (d.rb == 4'd0) d.uses_rb = 1'b0;
        if (d.rd == 4'd0) d.writeback = 1'b0;
        return d;
    endfunction

    // True when `later` may not issue in the same group as the older lane `early`.
    function automatic logic conflict(input insn_decode_t early, input insn_decode_t later);
        logic raw;
        logic waw;
        raw = early.writeback && ((later.uses_ra && later.ra == early.rd) ||
                                  (later.uses_rb && later.rb == early.rd));
        waw = early.writeback && later.writeback && (later.rd == early.rd);
        return early.ctrl.branch || raw || waw ||
               (early.ctrl.ldst && later.ctrl.ldst) ||
               (early.ctrl.mul && later.ctrl.mul);
    endfunction

    logic [15:0]                q_insn [DEPTH];
    hptr_t                      q_pc   [DEPTH];

    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    insn_decode_t [ISSUE_W-1:0] dec_q, dec_d;
    logic [ISSUE_W-1:0]         dec_valid_q, dec_valid_d;

    insn_decode_t               lane_dec [ISSUE_W];
    logic [ISSUE_W-1:0]         issue;
    logic [CNT_W-1:0]           n_issue;
    logic [CNT_W-1:0]           pop_n;
    logic [CNT_W-1:0]           push_n;
    logic                       ready;
    logic                       push_en;

    // Free-space check uses only the registered count; a same-cycle pop gives no credit.
    assign ready   = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
    assign push_en = bus.fetch_valid && ready && !bus.flush;

    always_comb begin
        push_n = '0;
        if (push_en) begin
            if (bus.fetch_count > FC_W'(FETCH_W)) begin
                push_n = CNT_W'(FETCH_W);
            end else begin
                push_n = CNT_W'(bus.fetch_count);
            end
        end
    end

    // Group formation: lane k needs lane k-1 issued, a queue entry, and no conflict with any
    // older lane of the group; this keeps issue in order with no skipping.
    always_comb begin
        logic ok;
        ok      = 1'b0;
        issue   = '0;
        n_issue = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            lane_dec[k] = decode(q_insn[rd_ptr_q + PTR_W'(k)], q_pc[rd_ptr_q + PTR_W'(k)]);
        end
        issue[0] = (count_q != '0);
        for (int k = 1; k < ISSUE_W; k++) begin
            ok = issue[k-1] && (CNT_W'(k) < count_q);
            for (int j = 0; j < k; j++) begin
                if (conflict(lane_dec[j], lane_dec[k])) ok = 1'b0;
            end
            issue[k] = ok;
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            n_issue = n_issue + CNT_W'(issue[k]);
        end
    end

    always_comb begin
        pop_n       = bus.stall ? '0 : n_issue;
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_n);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_n);
        count_d     = count_q + push_n - pop_n;
        dec_d       = dec_q;
        dec_valid_d = dec_valid_q;
        if (!bus.stall) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                dec_d[k] = issue[k] ? lane_dec[k] : '0;
            end
            dec_valid_d = issue;
        end
        if (bus.flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            dec_d       = '0;
            dec_valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dec_q       <= '0;
            dec_valid_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            dec_q       <= dec_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    // Queue storage needs no reset: entries are only read below the registered count.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (FC_W'(i) < bus.fetch_count) begin
                    q_insn[wr_ptr_q + PTR_W'(i)] <= bus.fetch_insn[16*i +: 16];
                    q_pc[wr_ptr_q + PTR_W'(i)]   <= bus.fetch_pc + hptr_t'(i);
                end
            end
        end
    end

    assign bus.fetch_ready = ready;
    assign bus.dec         = dec_q;
    assign bus.dec_valid   = dec_valid_q;
    assign bus.occupancy   = count_q;

    a_fetch_count_legal: assert property (@(posedge clk) disable iff (rst)
        bus.fetch_valid |-> (bus.fetch_count <= FC_W'(FETCH_W)));

endmodule

// File: tb/tb_core_decode_multi.sv
module tb_core_decode_multi;
    import core_decode_multi_pkg::*;

    localparam int unsigned FETCH_W = 2;
    localparam int unsigned ISSUE_W = 2;
    localparam int unsigned DEPTH   = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    core_decode_multi_if #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) bus ();

    core_decode_multi #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_beat(input logic [15:0] i0, input logic [15:0] i1,
                              input logic [15:0] pc, input logic [1:0] cnt);
        bus.fetch_valid = 1'b1;
        bus.fetch_insn  = {i1, i0};
        bus.fetch_pc    = pc;
        bus.fetch_count = cnt;
    endtask

    task automatic idle();
        bus.fetch_valid = 1'b0;
        bus.fetch_count = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.dec_valid !== 2'b00) begin errors++;
            $display("FAIL reset_dec_valid got %b want 00", bus.dec_valid); end
        checks++; if (bus.dec !== '0) begin errors++;
            $display("FAIL reset_dec got %h want 0", bus.dec); end
        checks++; if (bus.occupancy !== 4'd0) begin errors++;
            $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++;
            $display("FAIL reset_fetch_ready got %b want 1", bus.fetch_ready); end
    endtask

    task automatic test_pair();
        drive_beat(16'h1123, 16'h1456, 16'h0010, 2'd2);
        step();
        checks++; if (bus.occupancy !== 4'd2) begin errors++;
            $display("FAIL pair_occ got %0d want 2", bus.occupancy); end
        checks++; if (bus.dec_valid !== 2'b00) begin errors++;
            $display("FAIL pair_latency got %b want 00", bus.dec_valid); end
        idle();
        step();
        checks++; if (bus.dec_valid !== 2'b11) begin errors++;
            $display("FAIL pair_valid got %b want 11", bus.dec_valid); end
        checks++; if (bus.dec[0].pc !== 16'h0010) begin errors++;
            $display("FAIL pair_pc0 got %h want 0010", bus.dec[0].pc); end
        checks++; if (bus.dec[1].pc !== 16'h0011) begin errors++;
            $display("FAIL pair_pc1 got %h want 0011", bus.dec[1].pc); end
        checks++; if (bus.dec[1].insn !== 16'h1456 || bus.dec[1].rd !== 4'd4) begin errors++;
            $display("FAIL pair_lane1 got %h/%0d want 1456/4", bus.dec[1].insn, bus.dec[1].rd); end
        checks++; if (bus.occupancy !== 4'd0) begin errors++;
            $display("FAIL pair_drain got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_raw();
        drive_beat(16'h3305, 16'h1432, 16'h0020, 2'd2);  // IMM r3<-5 ; ALU r4=r3+r2
        step();
        idle();
        step();
        checks++; if (bus.dec_valid !== 2'b01) begin errors++;
            $display("FAIL raw_first got %b want 01", bus.dec_valid); end
        checks++; if (bus.dec[0].imm !== 8'h05 || bus.dec[0].rd !== 4'd3 ||
                      bus.dec[0].writeback !== 1'b1) begin errors++;
            $display("FAIL raw_imm got imm %h rd %0d wb %b want 05/3/1", bus.dec[0].imm,
                     bus.dec[0].rd, bus.dec[0].writeback); end
        checks++; if (bus.dec[1] !== '0) begin errors++;
            $display("FAIL raw_lane1_zero got %h want 0", bus.dec[1]); end
        step();
        checks++; if (bus.dec_valid !== 2'b01 || bus.dec[0].pc !== 16'h0021) begin errors++;
            $display("FAIL raw_second got %b pc %h want 01 pc 0021", bus.dec_valid,
                     bus.dec[0].pc); end
    endtask

    task automatic test_ldst();
        drive_beat(16'h4120, 16'h4561, 16'h0030, 2'd2);  // LD r1,[r2] ; LD r5,[r6+1]
        step();
        idle();
        step();
        checks++; if (bus.dec_valid !== 2'b01 || bus.dec[0].ctrl.ldst !== 1'b1 ||
                      bus.dec[0].ctrl.load !== 1'b1) begin errors++;
            $display("FAIL ldst_first got %b ldst %b want 01 ldst 1", bus.dec_valid,
                     bus.dec[0].ctrl.ldst); end
        step();
        checks++; if (bus.dec_valid !== 2'b01 || bus.dec[0].pc !== 16'h0031) begin errors++;
            $display("FAIL ldst_second got %b pc %h want 01 pc 0031", bus.dec_valid,
                     bus.dec[0].pc); end
    endtask

    task automatic test_branch();
        drive_beat(16'h6F04, 16'h1123, 16'h0038, 2'd2);  // BAL r15,+4 ; ALU r1=r2+r3
        step();
        idle();
        step();
        checks++; if (bus.dec_valid !== 2'b01 || bus.dec[0].ctrl.branch !== 1'b1) begin errors++;
            $display("FAIL branch_first got %b branch %b want 01 branch 1", bus.dec_valid,
                     bus.dec[0].ctrl.branch); end
        checks++; if (bus.dec[0].rd !== 4'd15 || bus.dec[0].imm !== 8'h04) begin errors++;
            $display("FAIL branch_fields got rd %0d imm %h want 15/04", bus.dec[0].rd,
                     bus.dec[0].imm); end
        step();
        checks++; if (bus.dec_valid !== 2'b01 || bus.dec[0].insn !== 16'h1123 ||
                      bus.dec[0].ctrl.branch !== 1'b0) begin errors++;
            $display("FAIL branch_second got %b insn %h want 01 insn 1123", bus.dec_valid,
                     bus.dec[0].insn); end
    endtask

    task automatic test_r0_nop();
        drive_beat(16'h0000, 16'h1005, 16'h003C, 2'd2);  // NOP ; ALU r0=r0+r5
        step();
        idle();
        step();
        checks++; if (bus.dec_valid !== 2'b11 || bus.dec[0].execute !== 1'b0) begin errors++;
            $display("FAIL r0_nop got %b exec %b want 11 exec 0", bus.dec_valid,
                     bus.dec[0].execute); end
        checks++; if (bus.dec[1].writeback !== 1'b0 || bus.dec[1].uses_ra !== 1'b0 ||
                      bus.dec[1].uses_rb !== 1'b1 || bus.dec[1].execute !== 1'b1) begin errors++;
            $display("FAIL r0_supp got wb %b ra %b rb %b ex %b want 0 0 1 1",
                     bus.dec[1].writeback, bus.dec[1].uses_ra, bus.dec[1].uses_rb,
                     bus.dec[1].execute); end
    endtask

    // Pointers sit at entry 2 here, so eight pushes wrap the queue.
    task automatic test_full_wrap();
        bus.stall = 1'b1;
        for (int b = 0; b < 4; b++) begin
            drive_beat(enc(4'h1, 4'(2*b+1), 4'd9, 4'd10), enc(4'h1, 4'(2*b+2), 4'd9, 4'd10),
                       16'h0040 + 16'(2*b), 2'd2);
            step();
            checks++; if (bus.occupancy !== 4'(2*(b+1))) begin errors++;
                $display("FAIL full_occ%0d got %0d want %0d", b, bus.occupancy, 2*(b+1)); end
        end
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++;
            $display("FAIL full_ready got %b want 0", bus.fetch_ready); end
        checks++; if (bus.dec_valid !== 2'b11 || bus.dec[1].insn !== 16'h1005) begin errors++;
            $display("FAIL stall_hold got %b insn %h want 11 insn 1005", bus.dec_valid,
                     bus.dec[1].insn); end
        drive_beat(16'h1999, 16'h1AAA, 16'h0080, 2'd2);
        step();
        checks++; if (bus.occupancy !== 4'd8) begin errors++;
            $display("FAIL full_drop got %0d want 8", bus.occupancy); end
        idle();
        bus.stall = 1'b0;
        for (int g = 0; g < 4; g++) begin
            step();
            checks++; if (bus.dec_valid !== 2'b11 || bus.dec[0].pc !== 16'h0040 + 16'(2*g) ||
                          bus.dec[1].pc !== 16'h0041 + 16'(2*g) ||
                          bus.dec[0].insn !== enc(4'h1, 4'(2*g+1), 4'd9, 4'd10)) begin errors++;
                $display("FAIL drain%0d got %b pc %h/%h insn %h", g, bus.dec_valid,
                         bus.dec[0].pc, bus.dec[1].pc, bus.dec[0].insn); end
            checks++; if (bus.occupancy !== 4'(8 - 2*(g+1))) begin errors++;
                $display("FAIL drain_occ%0d got %0d want %0d", g, bus.occupancy, 8-2*(g+1)); end
        end
        step();
        checks++; if (bus.dec_valid !== 2'b00 || bus.dec !== '0) begin errors++;
            $display("FAIL drain_bubble got %b want 00", bus.dec_valid); end
    endtask

    task automatic test_flush();
        drive_beat(16'h1123, 16'h1456, 16'h00A0, 2'd2);
        step();
        drive_beat(16'h1123, 16'h1456, 16'h00A2, 2'd2);
        step();
        bus.stall = 1'b1;
        for (int b = 0; b < 3; b++) begin
            drive_beat(16'h1123, 16'h1456, 16'h00A4 + 16'(2*b), 2'd2);
            step();
        end
        checks++; if (bus.occupancy !== 4'd8 || bus.dec_valid !== 2'b11) begin errors++;
            $display("FAIL flush_pre got occ %0d dv %b want 8/11", bus.occupancy,
                     bus.dec_valid); end
        drive_beat(16'h1777, 16'h1888, 16'h00F0, 2'd2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        idle();
        checks++; if (bus.occupancy !== 4'd0 || bus.dec_valid !== 2'b00 || bus.dec !== '0)
            begin errors++;
            $display("FAIL flush_clear got occ %0d dv %b want 0/00", bus.occupancy,
                     bus.dec_valid); end
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++;
            $display("FAIL flush_ready got %b want 1", bus.fetch_ready); end
        step();
        checks++; if (bus.occupancy !== 4'd0 || bus.dec_valid !== 2'b00) begin errors++;
            $display("FAIL flush_absent got occ %0d dv %b want 0/00", bus.occupancy,
                     bus.dec_valid); end
    endtask

    task automatic test_reset_mid();
        drive_beat(16'h1123, 16'h1456, 16'h00C0, 2'd2);
        step();
        drive_beat(16'h1123, 16'h1456, 16'h00C2, 2'd2);
        step();
        checks++; if (bus.dec_valid !== 2'b11 || bus.occupancy !== 4'd2) begin errors++;
            $display("FAIL mid_pre got dv %b occ %0d want 11/2", bus.dec_valid,
                     bus.occupancy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.dec_valid !== 2'b00 || bus.occupancy !== 4'd0 || bus.dec !== '0 ||
                      bus.fetch_ready !== 1'b1) begin errors++;
            $display("FAIL mid_reset got dv %b occ %0d rdy %b want 00/0/1", bus.dec_valid,
                     bus.occupancy, bus.fetch_ready); end
        step();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst             = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_insn  = '0;
        bus.fetch_pc    = '0;
        bus.fetch_count = '0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        test_reset();
        test_pair();
        test_raw();
        test_ldst();
        test_branch();
        test_r0_nop();
        test_full_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
